// File: rtl/div_sub_seq_if.sv
// Handshake and data bundle between the ALU sequencer and the restoring divider.
// The master drives operands and start; the slave returns status and results.
interface div_sub_seq_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_sub_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock,
// with a start/busy/done handshake carried on div_sub_seq_if.
module div_sub_seq #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    div_sub_seq_if.slave   bus
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH+1:0] trial;
    logic             unused_rem_msb;

    // The partial remainder MSB only ever holds 0 between iterations; the
    // shifted value and the trial subtract supply the extra bit themselves.
    assign unused_rem_msb = rem_q[WIDTH];
    assign rem_shift      = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign trial          = {1'b0, rem_shift} + {1'b0, ~{1'b0, div_q}}
                          + {{(WIDTH+1){1'b0}}, 1'b1};

    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        div_d         = div_q;
        cnt_d         = cnt_q;
        dz_d          = dz_q;
        done_d        = 1'b0;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    div_d = bus.divisor;
                    if (bus.divisor != '0) begin
                        state_d = RUN;
                        quo_d   = bus.dividend;
                        rem_d   = '0;
                        cnt_d   = CNT_W'(WIDTH - 1);
                        dz_d    = 1'b0;
                    end else begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = {1'b0, bus.dividend};
                        dz_d    = 1'b1;
                    end
                end
            end
            RUN: begin
                // Carry out of the trial means no borrow: keep the difference.
                if (trial[WIDTH+1]) begin
                    rem_d = trial[WIDTH:0];
                end else begin
                    rem_d = rem_shift;
                end
                quo_d = {quo_q[WIDTH-2:0], trial[WIDTH+1]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d       = IDLE;
                done_d        = 1'b1;
                quotient_d    = quo_q;
                remainder_d   = rem_q[WIDTH-1:0];
                div_by_zero_d = dz_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rem_q         <= '0;
            quo_q         <= '0;
            div_q         <= '0;
            cnt_q         <= '0;
            dz_q          <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            div_q         <= div_d;
            cnt_q         <= cnt_d;
            dz_q          <= dz_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_div_sub_seq.sv
// Self-checking bench for div_sub_seq: directed table, multi-cycle corner
// sequences, exhaustive sweep and random operands against an arithmetic model.
module tb_div_sub_seq;

    localparam int WIDTH      = 4;
    localparam int NORMAL_LAT = WIDTH + 1;
    localparam int ZERO_LAT   = 1;
    localparam int MAX_WAIT   = 20;

    typedef struct {
        int dividend;
        int divisor;
        int expQuotient;
        int expRemainder;
        int expDivByZero;
    } vector_t;

    logic clk;
    logic rst_n;
    int   nApplied     = 0;
    int   nMiscompares = 0;

    vector_t vectors[7];

    div_sub_seq_if #(.WIDTH(WIDTH)) bus ();

    div_sub_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guards against a handshake that never completes.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nApplied++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic void refDiv(input int a, input int b, output int q,
                                   output int r, output int dz);
        if (b == 0) begin
            q  = (1 << WIDTH) - 1;
            r  = a;
            dz = 1;
        end else begin
            q  = a / b;
            r  = a % b;
            dz = 0;
        end
    endfunction

    task automatic applyStimulus(input int a, input int b, input bit holdStart);
        bus.dividend = a[WIDTH-1:0];
        bus.divisor  = b[WIDTH-1:0];
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        if (!holdStart) bus.start = 1'b0;
    endtask

    task automatic waitDone(input int startEdge, output int edges, output int busyCycles);
        edges      = startEdge;
        busyCycles = 0;
        while (bus.done !== 1'b1 && edges < MAX_WAIT) begin
            if (bus.busy === 1'b1) busyCycles++;
            @(posedge clk);
            #1;
            edges++;
        end
        if (bus.busy === 1'b1) busyCycles++;
    endtask

    task automatic runCheck(input string name, input int a, input int b,
                            input int expQ, input int expR, input int expDz);
        int edges;
        int busyCycles;
        applyStimulus(a, b, 1'b0);
        waitDone(0, edges, busyCycles);
        checkOutput({name, " latency"}, edges, (expDz != 0) ? ZERO_LAT : NORMAL_LAT);
        checkOutput({name, " busy cycles"}, busyCycles, (expDz != 0) ? 0 : WIDTH);
        checkOutput({name, " quotient"}, 32'(bus.quotient), expQ);
        checkOutput({name, " remainder"}, 32'(bus.remainder), expR);
        checkOutput({name, " div_by_zero"}, 32'(bus.div_by_zero), expDz);
    endtask

    task automatic countDones(input int cycles, output int dones);
        dones = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dones++;
        end
    endtask

    initial begin
        int edges;
        int busyCycles;
        int dones;
        int q;
        int r;
        int dz;
        int a;
        int b;

        vectors[0] = '{13,  4,  3, 1, 0};
        vectors[1] = '{15,  1, 15, 0, 0};
        vectors[2] = '{ 3,  7,  0, 3, 0};
        vectors[3] = '{15, 15,  1, 0, 0};
        vectors[4] = '{ 0,  5,  0, 0, 0};
        vectors[5] = '{ 9,  0, 15, 9, 1};
        vectors[6] = '{ 8,  2,  4, 0, 0};

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #12;
        checkOutput("reset busy", 32'(bus.busy), 0);
        checkOutput("reset done", 32'(bus.done), 0);
        checkOutput("reset quotient", 32'(bus.quotient), 0);
        checkOutput("reset remainder", 32'(bus.remainder), 0);
        checkOutput("reset div_by_zero", 32'(bus.div_by_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            runCheck($sformatf("table%0d %0d/%0d", i, vectors[i].dividend, vectors[i].divisor),
                     vectors[i].dividend, vectors[i].divisor, vectors[i].expQuotient,
                     vectors[i].expRemainder, vectors[i].expDivByZero);
        end

        // Start pulses while RUN must be ignored and never queued.
        applyStimulus(12, 5, 1'b0);
        @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.dividend = 4'd7;
        bus.divisor  = 4'd2;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        waitDone(3, edges, busyCycles);
        checkOutput("ignore-start latency", edges, NORMAL_LAT);
        checkOutput("ignore-start quotient", 32'(bus.quotient), 2);
        checkOutput("ignore-start remainder", 32'(bus.remainder), 2);
        countDones(8, dones);
        checkOutput("ignore-start extra done", dones, 0);

        applyStimulus(7, 2, 1'b1);
        waitDone(0, edges, busyCycles);
        bus.start = 1'b0;
        checkOutput("held-start latency", edges, NORMAL_LAT);
        checkOutput("held-start busy cycles", busyCycles, WIDTH);
        checkOutput("held-start quotient", 32'(bus.quotient), 3);
        checkOutput("held-start remainder", 32'(bus.remainder), 1);
        @(posedge clk);
        #1;
        checkOutput("done single cycle", 32'(bus.done), 0);

        // Asynchronous reset in the middle of a divide.
        applyStimulus(14, 3, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort busy", 32'(bus.busy), 0);
        checkOutput("abort done", 32'(bus.done), 0);
        checkOutput("abort quotient", 32'(bus.quotient), 0);
        checkOutput("abort remainder", 32'(bus.remainder), 0);
        checkOutput("abort div_by_zero", 32'(bus.div_by_zero), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        countDones(8, dones);
        checkOutput("abort no done", dones, 0);
        runCheck("after-abort 14/3", 14, 3, 4, 2, 0);

        for (int x = 0; x < (1 << WIDTH); x++) begin
            for (int y = 0; y < (1 << WIDTH); y++) begin
                refDiv(x, y, q, r, dz);
                runCheck($sformatf("sweep %0d/%0d", x, y), x, y, q, r, dz);
            end
        end

        for (int k = 0; k < 40; k++) begin
            a = int'($urandom_range(0, (1 << WIDTH) - 1));
            b = int'($urandom_range(0, (1 << WIDTH) - 1));
            refDiv(a, b, q, r, dz);
            runCheck($sformatf("random %0d/%0d", a, b), a, b, q, r, dz);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompares);
        $finish;
    end

endmodule
